// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a 23LC512-style serial SRAM in sequential mode,
// oversampled on clk, with a backdoor port for preload and inspection.
module spi_sram_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata,
  output logic                 active
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ_DATA, S_WRITE_DATA, S_IGNORE
  } state_e;

  logic [7:0] mem_q [DEPTH];

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic        miso_q, miso_d;
  logic [7:0]  bd_rdata_q, bd_rdata_d;

  logic        cs_s, sclk_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_fall;
  logic [7:0]  rx_byte;
  logic [15:0] addr_inc, lo_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign spi_miso = miso_q;
  assign active   = (state_q != S_IDLE);
  assign bd_rdata = bd_rdata_q;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    bd_rdata_d  = mem_q[bd_addr];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    miso_d    = miso_q;
    mem_we    = 1'b0;
    rx_byte   = {rx_q[6:0], mosi_s};
    mem_wdata = rx_byte;
    addr_inc  = addr_q + 16'd1;
    lo_addr   = {addr_q[15:8], rx_byte};

    if (cs_s) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_IGNORE: miso_d = 1'b0;
        default: begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_CMD: begin
                  if (rx_byte == 8'h03) begin
                    state_d = S_ADDR_HI;
                    is_wr_d = 1'b0;
                  end else if (rx_byte == 8'h02) begin
                    state_d = S_ADDR_HI;
                    is_wr_d = 1'b1;
                  end else begin
                    state_d = S_IGNORE;
                  end
                end
                S_ADDR_HI: begin
                  addr_d  = {rx_byte, addr_q[7:0]};
                  state_d = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                  addr_d = lo_addr;
                  if (is_wr_q) begin
                    state_d = S_WRITE_DATA;
                  end else begin
                    tx_d    = mem_q[lo_addr[ADDR_BITS-1:0]];
                    state_d = S_READ_DATA;
                  end
                end
                S_READ_DATA: begin
                  addr_d = addr_inc;
                  tx_d   = mem_q[addr_inc[ADDR_BITS-1:0]];
                end
                S_WRITE_DATA: begin
                  mem_we = 1'b1;
                  addr_d = addr_inc;
                end
                default: ;
              endcase
            end
          end else if (sclk_fall && state_q == S_READ_DATA) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      endcase
    end
  end

  // Sync chains (cs_n included) clear to 0, so a cs_n already low at reset
  // release never looks like a falling edge; it must go high first.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      miso_q      <= 1'b0;
      bd_rdata_q  <= '0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      miso_q      <= miso_d;
      bd_rdata_q  <= bd_rdata_d;
    end
  end

  // Single write port: the SPI write takes it, dropping any concurrent backdoor write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= mem_wdata;
    end else if (bd_we) begin
      mem_q[bd_addr] <= bd_wdata;
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Randomized bench for spi_sram_responder against a transaction-level memory model.
module tb_spi_sram_responder;

  localparam int AB    = 8;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AB;
  localparam int HALF  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_cs_n = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          bd_we = 1'b0;
  logic [AB-1:0] bd_addr = '0;
  logic [7:0]    bd_wdata = '0;
  logic [7:0]    bd_rdata;
  logic          active;

  spi_sram_responder #(.ADDR_BITS(AB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .active(active)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic       chk_en = 1'b0;
  logic       exp_miso = 1'b0;
  logic       exp_active = 1'b0;
  int         bit_no = 0;

  // Per-cycle compare while sclk is high (the window in which the master samples).
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (spi_miso !== exp_miso) begin
        n_fail++;
        $display("FAIL miso bit %0d: got %b expected %b", bit_no, spi_miso, exp_miso);
      end
      n_checks++;
      if (active !== exp_active) begin
        n_fail++;
        $display("FAIL active bit %0d: got %b expected %b", bit_no, active, exp_active);
      end
    end
  end

  function automatic int idx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic bd_write(input logic [AB-1:0] a, input logic [7:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    tick(1);
    bd_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bd_check(input string name, input logic [AB-1:0] a, input logic [7:0] exp);
    bd_addr = a;
    tick(1);
    check8(name, bd_rdata, exp);
  endtask

  task automatic spi_bit(input logic mb, input logic eb, output logic got);
    spi_mosi = mb;
    tick(HALF);
    exp_miso = eb;
    chk_en   = 1'b1;
    got      = spi_miso;
    spi_sclk = 1'b1;
    tick(HALF);
    spi_sclk = 1'b0;
    chk_en   = 1'b0;
  endtask

  // Drives one transaction of nbits from txq; read bytes land in rxq.
  task automatic spi_txn(input int nbits);
    logic [7:0]  cmd, byt, cur;
    logic [15:0] a;
    logic        mb, eb, g;
    int          di;
    cmd = txq[0];
    a   = (txq.size() >= 3) ? {txq[1], txq[2]} : 16'h0000;
    rxq = {};
    cur = '0;
    spi_cs_n   = 1'b0;
    exp_active = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bit_no = i;
      byt = txq[i/8];
      mb  = byt[7 - (i % 8)];
      eb  = 1'b0;
      if (cmd == 8'h03 && i >= 24) begin
        di  = (i - 24) / 8;
        byt = model_mem[idx(a + 16'(di))];
        eb  = byt[7 - ((i - 24) % 8)];
      end
      spi_bit(mb, eb, g);
      if (i >= 24) begin
        cur = {cur[6:0], g};
        if ((i - 24) % 8 == 7) rxq.push_back(cur);
      end
    end
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(SS + 1);
    check1("active_after_cs_high", active, 1'b0);
    check1("miso_after_cs_high", spi_miso, 1'b0);
    if (cmd == 8'h02 && nbits >= 32)
      for (int k = 0; k < (nbits - 24) / 8; k++) model_mem[idx(a + 16'(k))] = txq[3 + k];
    tick(HALF);
  endtask

  initial begin
    logic        g;
    logic [7:0]  rb;
    logic [15:0] ra;
    int          kind, nb, nbits;

    tick(3);
    check1("reset_miso", spi_miso, 1'b0);
    check1("reset_active", active, 1'b0);
    check8("reset_bd_rdata", bd_rdata, 8'h00);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < DEPTH; i++) bd_write(AB'(i), 8'($urandom));
    bd_write(8'h12, 8'hA5);
    bd_write(8'h13, 8'h3C);

    txq = {8'h03, 8'h00, 8'h12, 8'h00, 8'h00};
    spi_txn(40);
    check8("read_0x12", rxq[0], 8'hA5);
    check8("read_0x13", rxq[1], 8'h3C);

    txq = {8'h02, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33};
    spi_txn(48);
    bd_check("wr_0x40", 8'h40, 8'h11);
    bd_check("wr_0x41", 8'h41, 8'h22);
    bd_check("wr_0x42", 8'h42, 8'h33);

    txq = {8'h02, 8'h12, 8'hFF, 8'hAA, 8'hBB};
    spi_txn(40);
    bd_check("alias_0xFF", 8'hFF, 8'hAA);
    bd_check("alias_0x00", 8'h00, 8'hBB);
    txq = {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
    spi_txn(40);
    check8("wrap_rd_0xFFFF", rxq[0], 8'hAA);
    check8("wrap_rd_0x0000", rxq[1], 8'hBB);

    bd_write(8'h50, 8'h77);
    txq = {8'h02, 8'h00, 8'h50, 8'hFF};
    spi_txn(29);
    bd_check("partial_0x50", 8'h50, 8'h77);
    txq = {8'h03, 8'h00, 8'h50, 8'h00};
    spi_txn(32);
    check8("partial_reread", rxq[0], 8'h77);

    txq = {8'h9F, 8'h02, 8'h12, 8'h55};
    spi_txn(32);
    txq = {8'h03, 8'h00, 8'h12, 8'h00};
    spi_txn(32);
    check8("after_ignore", rxq[0], 8'hA5);

    // Reset while streaming: bit 7 of 0xA5 is on MISO when reset hits.
    spi_cs_n = 1'b0;
    exp_active = 1'b1;
    txq = {8'h03, 8'h00, 8'h12};
    for (int i = 0; i < 24; i++) begin
      rb = txq[i/8];
      spi_bit(rb[7 - (i % 8)], 1'b0, g);
    end
    tick(HALF);
    check1("pre_reset_miso", spi_miso, 1'b1);
    reset = 1'b1;
    tick(1);
    check1("reset_mid_miso", spi_miso, 1'b0);
    check1("reset_mid_active", active, 1'b0);
    reset = 1'b0;
    exp_active = 1'b0;
    for (int i = 0; i < 16; i++) spi_bit(1'($urandom), 1'b0, g);
    spi_cs_n = 1'b1;
    tick(HALF);
    txq = {8'h03, 8'h00, 8'h12, 8'h00};
    spi_txn(32);
    check8("read_after_reset", rxq[0], 8'hA5);

    for (int t = 0; t < 25; t++) begin
      kind = int'($urandom_range(0, 3));
      nb   = int'($urandom_range(1, 4));
      ra   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      txq  = {8'h03, ra[15:8], ra[7:0]};
      if (kind == 1 || kind == 3) txq[0] = 8'h02;
      if (kind == 2) begin
        do rb = 8'($urandom); while (rb == 8'h02 || rb == 8'h03);
        txq[0] = rb;
      end
      for (int k = 0; k <= nb; k++) txq.push_back(8'($urandom));
      nbits = 24 + 8 * nb + ((kind == 3) ? int'($urandom_range(1, 7)) : 0);
      spi_txn(nbits);
      for (int k = 0; k < 2; k++) begin
        rb = 8'($urandom);
        bd_check("rand_bd", rb, model_mem[rb]);
      end
      if ($urandom_range(0, 2) == 0) bd_write(8'($urandom), 8'($urandom));
    end

    for (int i = 0; i < DEPTH; i++) bd_check("final_mem", AB'(i), model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
